// File: rtl/vector_bitwise_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : vector_bitwise_unit_if
//  Description : Command / operand / result bundle of the vector bitwise unit.
//                master = issuing side, slave = execution unit.
//  Revision    : 1.0  initial release
// ============================================================================
interface vector_bitwise_unit_if #(
   parameter int ELEM_W = 32,
   parameter int LANES  = 4,
   parameter int VL_W   = 6
);
   logic                    cmd_valid;
   logic                    cmd_ready;
   logic [2:0]              cmd_op;
   logic [VL_W-1:0]         cmd_vl;
   logic                    cmd_red;
   logic                    in_valid;
   logic                    in_ready;
   logic [LANES*ELEM_W-1:0] in_a;
   logic [LANES*ELEM_W-1:0] in_b;
   logic [LANES-1:0]        in_mask;
   logic                    out_valid;
   logic                    out_ready;
   logic [LANES*ELEM_W-1:0] out_data;
   logic [LANES-1:0]        out_lane_en;
   logic [ELEM_W-1:0]       red_result;
   logic                    busy;
   logic                    done;

   modport master (
      output cmd_valid, cmd_op, cmd_vl, cmd_red, in_valid, in_a, in_b, in_mask, out_ready,
      input  cmd_ready, in_ready, out_valid, out_data, out_lane_en, red_result, busy, done
   );

   modport slave (
      input  cmd_valid, cmd_op, cmd_vl, cmd_red, in_valid, in_a, in_b, in_mask, out_ready,
      output cmd_ready, in_ready, out_valid, out_data, out_lane_en, red_result, busy, done
   );
endinterface
`default_nettype wire

// File: rtl/vector_bitwise_unit.sv
`default_nettype none
// ============================================================================
//  Module      : vector_bitwise_unit
//  Description : Multi-lane, vector-length-aware bitwise execution unit with
//                per-lane masking, tail zeroing and a single output register.
//                Optional reduction accumulator enabled by macro VBW_REDUCE_EN.
//  Revision    : 1.0  initial release
// ============================================================================
module vector_bitwise_unit #(
   parameter int ELEM_W   = 32,
   parameter int LANES    = 4,
   parameter int VLEN_MAX = 32,
   parameter int VL_W     = $clog2(VLEN_MAX + 1)
) (
   input  wire logic             clk,
   input  wire logic             reset,
   vector_bitwise_unit_if.slave  bus
);
   localparam int BEATS_MAX = VLEN_MAX / LANES;
   localparam int BEAT_W    = $clog2(BEATS_MAX + 1);
   localparam int CMP_W     = VL_W + 1;
   localparam logic [CMP_W-1:0] C_LANES = CMP_W'(LANES);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_RUN   = 2'd1;
   localparam logic [1:0] S_DRAIN = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   localparam logic [2:0] OP_AND  = 3'd0;
   localparam logic [2:0] OP_OR   = 3'd1;
   localparam logic [2:0] OP_XOR  = 3'd2;
   localparam logic [2:0] OP_NAND = 3'd3;
   localparam logic [2:0] OP_NOR  = 3'd4;
   localparam logic [2:0] OP_XNOR = 3'd5;
   localparam logic [2:0] OP_ANDN = 3'd6;

   logic [1:0]              state, state_next;
   logic [2:0]              op_q;
   logic [VL_W-1:0]         vl_eff;
   logic [VL_W-1:0]         vl_clamped;
   logic [BEAT_W-1:0]       beat;
   logic [CMP_W-1:0]        base;
   logic                    cmd_fire, in_fire, last_beat, red_mode;
   logic                    cmd_ready_c, in_ready_c, busy_c, done_c;
   logic                    out_valid_q;
   logic [LANES*ELEM_W-1:0] out_data_q, lane_data;
   logic [LANES-1:0]        out_lane_en_q, lane_en;

   function automatic logic [ELEM_W-1:0] op_apply(input logic [2:0] op,
                                                  input logic [ELEM_W-1:0] a,
                                                  input logic [ELEM_W-1:0] b);
      case (op)
         OP_AND:  op_apply = a & b;
         OP_OR:   op_apply = a | b;
         OP_XOR:  op_apply = a ^ b;
         OP_NAND: op_apply = ~(a & b);
         OP_NOR:  op_apply = ~(a | b);
         OP_XNOR: op_apply = ~(a ^ b);
         OP_ANDN: op_apply = a & ~b;
         default: op_apply = '0;
      endcase
   endfunction

   assign vl_clamped = (bus.cmd_vl > VL_W'(VLEN_MAX)) ? VL_W'(VLEN_MAX) : bus.cmd_vl;
   assign cmd_fire   = bus.cmd_valid & cmd_ready_c;
   assign in_fire    = bus.in_valid & in_ready_c;
   assign base       = CMP_W'(beat) * C_LANES;
   assign last_beat  = (base + C_LANES) >= {1'b0, vl_eff};

   // Per-lane element classification: tail, masked-off (A passes through) or active op.
   for (genvar i = 0; i < LANES; i++) begin : g_lane
      logic [CMP_W-1:0]  elem;
      logic              active;
      logic [ELEM_W-1:0] a, b;
      assign elem       = base + CMP_W'(i);
      assign active     = elem < {1'b0, vl_eff};
      assign a          = bus.in_a[i*ELEM_W +: ELEM_W];
      assign b          = bus.in_b[i*ELEM_W +: ELEM_W];
      assign lane_en[i] = active & bus.in_mask[i];
      assign lane_data[i*ELEM_W +: ELEM_W] = !active      ? '0 :
                                             bus.in_mask[i] ? op_apply(op_q, a, b) : a;
   end

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= S_IDLE;
      else       state <= state_next;
   end

   // Next-state logic.
   always_comb begin
      state_next = state;
      case (state)
         S_IDLE:  if (bus.cmd_valid) state_next = (vl_clamped == '0) ? S_DONE : S_RUN;
         S_RUN:   if (in_fire && last_beat) state_next = S_DRAIN;
         S_DRAIN: if (!out_valid_q || bus.out_ready) state_next = S_DONE;
         S_DONE:  state_next = S_IDLE;
         default: state_next = S_IDLE;
      endcase
   end

   // State-decoded handshake and status outputs.
   always_comb begin
      cmd_ready_c = 1'b0;
      in_ready_c  = 1'b0;
      busy_c      = 1'b1;
      done_c      = 1'b0;
      case (state)
         S_IDLE: begin
            cmd_ready_c = 1'b1;
            busy_c      = 1'b0;
         end
         S_RUN:   in_ready_c = red_mode | !out_valid_q | bus.out_ready;
         S_DONE:  done_c = 1'b1;
         default: ;
      endcase
   end

   // Command latch and beat counter.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         op_q   <= '0;
         vl_eff <= '0;
         beat   <= '0;
      end else if (cmd_fire) begin
         op_q   <= bus.cmd_op;
         vl_eff <= vl_clamped;
         beat   <= '0;
      end else if (in_fire) begin
         beat   <= beat + BEAT_W'(1);
      end
   end

   // Single output register: loads on accept, clears valid when drained.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_valid_q   <= 1'b0;
         out_data_q    <= '0;
         out_lane_en_q <= '0;
      end else if (in_fire && !red_mode) begin
         out_valid_q   <= 1'b1;
         out_data_q    <= lane_data;
         out_lane_en_q <= lane_en;
      end else if (bus.out_ready) begin
         out_valid_q   <= 1'b0;
      end
   end

`ifdef VBW_REDUCE_EN
   logic              red_q;
   logic [ELEM_W-1:0] acc, acc_next, red_result_q;

   assign red_mode       = red_q;
   assign bus.red_result = red_result_q;

   // Fold the op results of enabled lanes of the current beat into the accumulator.
   always_comb begin
      acc_next = acc;
      for (int i = 0; i < LANES; i++) begin
         if (lane_en[i]) begin
            case (op_q)
               OP_AND:  acc_next = acc_next & lane_data[i*ELEM_W +: ELEM_W];
               OP_OR:   acc_next = acc_next | lane_data[i*ELEM_W +: ELEM_W];
               OP_XOR:  acc_next = acc_next ^ lane_data[i*ELEM_W +: ELEM_W];
               default: ;
            endcase
         end
      end
   end

   // Accumulator and published reduction result; non-logic ops publish zero.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         red_q        <= 1'b0;
         acc          <= '0;
         red_result_q <= '0;
      end else begin
         if (cmd_fire) begin
            red_q <= bus.cmd_red;
            acc   <= (bus.cmd_op == OP_AND) ? '1 : '0;
         end else if (in_fire && red_q) begin
            acc   <= acc_next;
         end
         if (cmd_fire && vl_clamped == '0 && bus.cmd_red)
            red_result_q <= (bus.cmd_op == OP_AND) ? '1 : '0;
         else if (state == S_DRAIN && state_next == S_DONE && red_q)
            red_result_q <= (op_q <= OP_XOR) ? acc : '0;
      end
   end
`else
   logic unused_red;
   assign unused_red     = bus.cmd_red;
   assign red_mode       = 1'b0;
   assign bus.red_result = '0;
`endif

   assign bus.cmd_ready   = cmd_ready_c;
   assign bus.in_ready    = in_ready_c;
   assign bus.busy        = busy_c;
   assign bus.done        = done_c;
   assign bus.out_valid   = out_valid_q;
   assign bus.out_data    = out_data_q;
   assign bus.out_lane_en = out_lane_en_q;
endmodule
`default_nettype wire

// File: tb/tb_vector_bitwise_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vector_bitwise_unit
//  Description : Self-checking bench for vector_bitwise_unit with an
//                element-level reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_vector_bitwise_unit;
   localparam int ELEM_W   = 32;
   localparam int LANES    = 4;
   localparam int VLEN_MAX = 32;
   localparam int VL_W     = $clog2(VLEN_MAX + 1);
   localparam int DW       = ELEM_W * LANES;
   localparam int NBMAX    = VLEN_MAX / LANES;

   typedef struct packed {
      logic [DW-1:0]    data;
      logic [LANES-1:0] en;
   } beat_t;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   vector_bitwise_unit_if #(.ELEM_W(ELEM_W), .LANES(LANES), .VL_W(VL_W)) bus ();

   vector_bitwise_unit #(.ELEM_W(ELEM_W), .LANES(LANES), .VLEN_MAX(VLEN_MAX), .VL_W(VL_W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int checks = 0;
   int errors = 0;

   logic [DW-1:0]    a_mem [0:NBMAX-1];
   logic [DW-1:0]    b_mem [0:NBMAX-1];
   logic [LANES-1:0] m_mem [0:NBMAX-1];

   // Monitor-owned observation state
   beat_t obs_q[$];
   int    cyc = 0;
   int    done_cnt = 0, outv_cnt = 0;
   int    done_cyc = 0, last_acc_cyc = 0, cmd_acc_cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (!reset) begin
         if (bus.out_valid && bus.out_ready) begin
            obs_q.push_back('{data: bus.out_data, en: bus.out_lane_en});
            last_acc_cyc = cyc;
         end
         if (bus.out_valid) outv_cnt++;
         if (bus.cmd_valid && bus.cmd_ready) cmd_acc_cyc = cyc;
         if (bus.done) begin
            done_cnt++;
            done_cyc = cyc;
         end
      end
   end

   task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [ELEM_W-1:0] ref_op(input logic [2:0] op,
                                                input logic [ELEM_W-1:0] a,
                                                input logic [ELEM_W-1:0] b);
      case (op)
         3'd0:    return a & b;
         3'd1:    return a | b;
         3'd2:    return a ^ b;
         3'd3:    return ~(a & b);
         3'd4:    return ~(a | b);
         3'd5:    return ~(a ^ b);
         3'd6:    return a & ~b;
         default: return '0;
      endcase
   endfunction

   function automatic logic pick_ready(input int rmode);
      if (rmode == 0) return 1'b1;
      return 1'($urandom_range(0, 1));
   endfunction

   task automatic fill_rand();
      for (int k = 0; k < NBMAX; k++) begin
         a_mem[k] = {$urandom, $urandom, $urandom, $urandom};
         b_mem[k] = {$urandom, $urandom, $urandom, $urandom};
         m_mem[k] = LANES'($urandom);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #2;
   endtask

   task automatic issue_cmd(input logic [2:0] op, input int vl, input bit red);
      bus.cmd_op    = op;
      bus.cmd_vl    = VL_W'(vl);
      bus.cmd_red   = red;
      bus.cmd_valid = 1'b1;
      @(negedge clk);
      chk("cmd_ready_idle", bus.cmd_ready, 1'b1);
      next_cycle();
      bus.cmd_valid = 1'b0;
   endtask

   // One complete command: model, drive, drain, compare.
   task automatic run_cmd(input logic [2:0] op, input int vl, input bit red,
                          input int rmode, input bit bp_test, input string name);
      int vle, nb, beat, budget, hold, e, start_done, start_obs, start_outv, nobs;
      bit red_active;
      beat_t exp_q[$];
      beat_t b;
      logic [ELEM_W-1:0] ea, eb, r, exp_red;

      vle = (vl > VLEN_MAX) ? VLEN_MAX : vl;
      nb  = (vle + LANES - 1) / LANES;
      red_active = 1'b0;
`ifdef VBW_REDUCE_EN
      red_active = red;
`endif
      exp_red = (op == 3'd0) ? '1 : '0;
      for (int k = 0; k < nb; k++) begin
         b.data = '0;
         b.en   = '0;
         for (int l = 0; l < LANES; l++) begin
            e  = k * LANES + l;
            ea = a_mem[k][l*ELEM_W +: ELEM_W];
            eb = b_mem[k][l*ELEM_W +: ELEM_W];
            if (e < vle) begin
               if (m_mem[k][l]) begin
                  r = ref_op(op, ea, eb);
                  b.data[l*ELEM_W +: ELEM_W] = r;
                  b.en[l] = 1'b1;
                  if (op == 3'd0) exp_red = exp_red & r;
                  else if (op == 3'd1) exp_red = exp_red | r;
                  else if (op == 3'd2) exp_red = exp_red ^ r;
               end else begin
                  b.data[l*ELEM_W +: ELEM_W] = ea;
               end
            end
         end
         if (!red_active) exp_q.push_back(b);
      end
      if (op > 3'd2) exp_red = '0;

      start_done = done_cnt;
      start_obs  = obs_q.size();
      start_outv = outv_cnt;
      bus.out_ready = 1'b1;
      issue_cmd(op, vl, red);

      beat = 0;
      budget = 0;
      hold = bp_test ? 5 : 0;
      while (beat < nb && budget < 2000) begin
         bus.in_valid = 1'b1;
         bus.in_a     = a_mem[beat];
         bus.in_b     = b_mem[beat];
         bus.in_mask  = m_mem[beat];
         if (bp_test && beat == 1 && hold > 0) begin
            bus.out_ready = 1'b0;
            @(negedge clk);
            chk({name, "_bp_in_ready"}, bus.in_ready, 1'b0);
            chk({name, "_bp_valid"}, bus.out_valid, 1'b1);
            chk({name, "_bp_hold_data"}, bus.out_data, exp_q[0].data);
            hold--;
         end else begin
            bus.out_ready = pick_ready(rmode);
            @(negedge clk);
            if (bus.in_ready) beat++;
         end
         budget++;
         next_cycle();
      end
      bus.in_valid = 1'b0;
      chk({name, "_in_timeout"}, (budget < 2000), 1'b1);

      budget = 0;
      while (done_cnt == start_done && budget < 200) begin
         bus.out_ready = pick_ready(rmode);
         next_cycle();
         budget++;
      end
      bus.out_ready = 1'b1;
      repeat (3) next_cycle();

      chk({name, "_done_once"}, done_cnt - start_done, 1);
      nobs = obs_q.size() - start_obs;
      chk({name, "_beat_count"}, nobs, exp_q.size());
      for (int i = 0; i < exp_q.size() && i < nobs; i++) begin
         chk($sformatf("%s_data%0d", name, i), obs_q[start_obs+i].data, exp_q[i].data);
         chk($sformatf("%s_en%0d", name, i), obs_q[start_obs+i].en, exp_q[i].en);
      end
      if (exp_q.size() > 0) chk({name, "_done_lat"}, done_cyc, last_acc_cyc + 1);
      if (vle == 0)         chk({name, "_done_vl0"}, done_cyc, cmd_acc_cyc + 1);
      if (red_active || vle == 0) chk({name, "_no_outv"}, outv_cnt - start_outv, 0);
      if (red_active) chk({name, "_red_result"}, bus.red_result, exp_red);
`ifndef VBW_REDUCE_EN
      chk({name, "_red_zero"}, bus.red_result, 0);
`endif
      chk({name, "_idle_busy"}, bus.busy, 1'b0);
      chk({name, "_idle_ready"}, bus.cmd_ready, 1'b1);
   endtask

   initial begin
      int start_done;
      bus.cmd_valid = 1'b0;
      bus.cmd_op    = '0;
      bus.cmd_vl    = '0;
      bus.cmd_red   = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_a      = '0;
      bus.in_b      = '0;
      bus.in_mask   = '0;
      bus.out_ready = 1'b1;

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_out_valid", bus.out_valid, 1'b0);
      chk("rst_out_data", bus.out_data, '0);
      chk("rst_lane_en", bus.out_lane_en, '0);
      chk("rst_red", bus.red_result, '0);
      chk("rst_busy", bus.busy, 1'b0);
      chk("rst_done", bus.done, 1'b0);
      next_cycle();
      reset = 1'b0;
      next_cycle();
      chk("idle_cmd_ready", bus.cmd_ready, 1'b1);

      // OR, vl=8, full masks, fixed data
      for (int k = 0; k < NBMAX; k++) begin
         a_mem[k] = {LANES{32'hF0F0F0F0}};
         b_mem[k] = {LANES{32'h0F0F0000}};
         m_mem[k] = '1;
      end
      run_cmd(3'd1, 8, 1'b0, 0, 1'b0, "or_vl8");
      chk("or_vl8_lane_value", obs_q[obs_q.size()-1].data, {LANES{32'hFFFFF0F0}});

      // XNOR, vl=6: tail lanes of beat 2
      fill_rand();
      m_mem[0] = '1;
      m_mem[1] = '1;
      run_cmd(3'd5, 6, 1'b0, 0, 1'b0, "xnor_vl6");
      chk("xnor_vl6_tail_en", obs_q[obs_q.size()-1].en, 4'b0011);

      // ANDN with mask 0101
      a_mem[0] = {LANES{32'hFFFFFFFF}};
      b_mem[0] = {LANES{32'h0000FFFF}};
      m_mem[0] = 4'b0101;
      run_cmd(3'd6, 4, 1'b0, 0, 1'b0, "andn_mask");
      chk("andn_mask_value", obs_q[obs_q.size()-1].data,
          {32'hFFFFFFFF, 32'hFFFF0000, 32'hFFFFFFFF, 32'hFFFF0000});

      // Backpressure and zero-length command
      fill_rand();
      run_cmd(3'd0, 8, 1'b0, 0, 1'b1, "bp");
      run_cmd(3'd2, 0, 1'b0, 0, 1'b0, "vl0");

      // Reset mid-RUN after the first of four beats
      fill_rand();
      start_done = done_cnt;
      bus.out_ready = 1'b1;
      issue_cmd(3'd0, 16, 1'b0);
      bus.in_valid = 1'b1;
      bus.in_a     = a_mem[0];
      bus.in_b     = b_mem[0];
      bus.in_mask  = m_mem[0];
      @(negedge clk);
      chk("mid_in_ready", bus.in_ready, 1'b1);
      @(posedge clk);
      #3;
      bus.in_valid = 1'b0;
      chk("mid_pre_valid", bus.out_valid, 1'b1);
      reset = 1'b1;
      #1;
      chk("mid_rst_valid", bus.out_valid, 1'b0);
      chk("mid_rst_data", bus.out_data, '0);
      chk("mid_rst_en", bus.out_lane_en, '0);
      chk("mid_rst_busy", bus.busy, 1'b0);
      chk("mid_rst_done", bus.done, 1'b0);
      repeat (2) @(posedge clk);
      #2;
      reset = 1'b0;
      repeat (4) next_cycle();
      chk("mid_no_done", done_cnt - start_done, 0);

      // vl=40 clamps to 32 elements (8 beats)
      fill_rand();
      run_cmd(3'($urandom_range(0, 6)), 40, 1'b0, 1, 1'b0, "clamp40");

      // Cmd with reduction request
      fill_rand();
      a_mem[0] = {32'h0000_00F8, 32'h0000_0044, 32'h0000_0023, 32'h0000_0011};
      b_mem[0] = {32'h0000_00F0, 32'h0000_0040, 32'h0000_0021, 32'h0000_0010};
      m_mem[0] = '1;
      run_cmd(3'd2, 4, 1'b1, 0, 1'b0, "red_xor");
`ifdef VBW_REDUCE_EN
      chk("red_xor_value", bus.red_result, 32'h0000000F);
      for (int t = 0; t < 6; t++) begin
         fill_rand();
         run_cmd(3'($urandom_range(0, 7)), $urandom_range(0, 36), 1'b1, 1, 1'b0,
                 $sformatf("red_rand%0d", t));
      end
`endif

      // Randomized commands against the model
      for (int t = 0; t < 12; t++) begin
         fill_rand();
         run_cmd(3'($urandom_range(0, 7)), $urandom_range(0, 36), 1'b0, 1, 1'b0,
                 $sformatf("rand%0d", t));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
`default_nettype wire
